// File: rtl/pulse_gen_pkg.sv
// Shared encodings for the multi-channel event-to-spike converter:
// edge-select modes, per-channel state, and the edge qualifier.
package pulse_gen_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PULSE  = 2'b01,
        ST_REFRAC = 2'b10
    } ch_state_t;

    // Mode 11 is reserved and falls back to rising-edge detection.
    function automatic logic edge_detect(input logic [1:0] mode,
                                         input logic       cur,
                                         input logic       prev);
        case (mode)
            MODE_FALL: return !cur && prev;
            MODE_BOTH: return cur != prev;
            default:   return cur && !prev;
        endcase
    endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One converter channel: level synchroniser, edge qualifier, spike/refractory
// sequencer and sticky missed-edge flag.
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PW_W        = 4,
    parameter int RF_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            evt_level,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [PW_W-1:0] pulse_len,
    input  logic [RF_W-1:0] refrac_len,
    input  logic            miss_clr,
    output logic            spike,
    output logic            busy,
    output logic            miss
);
    localparam int CW = (PW_W > RF_W) ? PW_W : RF_W;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    ch_state_t              state_reg;
    logic [CW-1:0]          cnt_reg;
    logic [RF_W-1:0]        rf_reg;
    logic                   spike_reg;
    logic                   busy_reg;
    logic                   miss_reg;
    logic                   edge_hit;
    logic [PW_W-1:0]        len_eff;

    assign edge_hit = edge_detect(mode, sync_reg[SYNC_STAGES-1], prev_reg);
    assign len_eff  = (pulse_len == '0) ? PW_W'(1) : pulse_len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            rf_reg    <= '0;
            spike_reg <= 1'b0;
            busy_reg  <= 1'b0;
            miss_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], evt_level};
            prev_reg <= sync_reg[SYNC_STAGES-1];

            // A new miss in the same cycle as a clear must survive.
            if (edge_hit && (state_reg != ST_IDLE || !en))
                miss_reg <= 1'b1;
            else if (miss_clr)
                miss_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (edge_hit && en) begin
                        state_reg <= ST_PULSE;
                        cnt_reg   <= CW'(len_eff) - CW'(1);
                        rf_reg    <= refrac_len;
                        spike_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else if (rf_reg != '0) begin
                        state_reg <= ST_REFRAC;
                        cnt_reg   <= CW'(rf_reg) - CW'(1);
                        spike_reg <= 1'b0;
                    end else begin
                        state_reg <= ST_IDLE;
                        spike_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_REFRAC: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    spike_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign spike = spike_reg;
    assign busy  = busy_reg;
    assign miss  = miss_reg;

endmodule

// File: rtl/pulse_gen_mc.sv
// Multi-channel event-to-spike converter: NCH independent channels sharing
// one set of mode/length/enable settings.
module pulse_gen_mc
    import pulse_gen_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PW_W        = 4,
    parameter int RF_W        = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NCH-1:0]  i_event,
    input  logic            i_en,
    input  logic [1:0]      i_mode,
    input  logic [PW_W-1:0] i_pulse_len,
    input  logic [RF_W-1:0] i_refrac_len,
    input  logic [NCH-1:0]  i_miss_clr,
    output logic [NCH-1:0]  o_spike,
    output logic [NCH-1:0]  o_busy,
    output logic [NCH-1:0]  o_miss
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        pulse_gen_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .PW_W        (PW_W),
            .RF_W        (RF_W)
        ) u_ch (
            .clk        (i_clk),
            .rst_n      (i_rst_n),
            .evt_level  (i_event[gi]),
            .en         (i_en),
            .mode       (i_mode),
            .pulse_len  (i_pulse_len),
            .refrac_len (i_refrac_len),
            .miss_clr   (i_miss_clr[gi]),
            .spike      (o_spike[gi]),
            .busy       (o_busy[gi]),
            .miss       (o_miss[gi])
        );
    end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Bench for pulse_gen_mc: scripted scenarios plus random traffic, checked each
// cycle against a timestamp-based reference model of spike/busy/miss.
module tb_pulse_gen_mc;
    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int PW  = 4;
    localparam int RF  = 8;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [NCH-1:0] i_event;
    logic           i_en;
    logic [1:0]     i_mode;
    logic [PW-1:0]  i_pulse_len;
    logic [RF-1:0]  i_refrac_len;
    logic [NCH-1:0] i_miss_clr;
    logic [NCH-1:0] o_spike;
    logic [NCH-1:0] o_busy;
    logic [NCH-1:0] o_miss;

    pulse_gen_mc #(.NCH(NCH), .SYNC_STAGES(SS), .PW_W(PW), .RF_W(RF)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_event      (i_event),
        .i_en         (i_en),
        .i_mode       (i_mode),
        .i_pulse_len  (i_pulse_len),
        .i_refrac_len (i_refrac_len),
        .i_miss_clr   (i_miss_clr),
        .o_spike      (o_spike),
        .o_busy       (o_busy),
        .o_miss       (o_miss)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: sampled-level history plus spike/busy time windows.
    logic           hist [NCH][0:SS];
    int             start_t  [NCH];
    int             spk_end  [NCH];
    int             busy_end [NCH];
    logic [NCH-1:0] m_spike, m_busy, m_miss;

    task automatic model_step();
        logic cur, prv, hit, idle;
        int   len;
        for (int c = 0; c < NCH; c++) begin
            if (!i_rst_n) begin
                for (int i = 0; i <= SS; i++) hist[c][i] = 1'b0;
                start_t[c]  = -1000;
                spk_end[c]  = -1000;
                busy_end[c] = -1000;
                m_miss[c]   = 1'b0;
            end else begin
                // Decision at this edge uses the level sampled SS edges ago vs. the one before.
                cur = hist[c][SS-1];
                prv = hist[c][SS];
                case (i_mode)
                    2'b01:   hit = !cur && prv;
                    2'b10:   hit = cur != prv;
                    default: hit = cur && !prv;
                endcase
                idle = cyc > busy_end[c];
                if (hit && idle && i_en) begin
                    len         = (i_pulse_len == 0) ? 1 : int'(i_pulse_len);
                    start_t[c]  = cyc;
                    spk_end[c]  = cyc + len;
                    busy_end[c] = cyc + len + int'(i_refrac_len);
                end
                if (hit && (!idle || !i_en)) m_miss[c] = 1'b1;
                else if (i_miss_clr[c])      m_miss[c] = 1'b0;
                for (int i = SS; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = i_event[c];
            end
            m_spike[c] = (cyc >= start_t[c]) && (cyc < spk_end[c]);
            m_busy[c]  = (cyc >= start_t[c]) && (cyc < busy_end[c]);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        cyc++;
        model_step();
        @(negedge i_clk);
    endtask

    task automatic settle(input int n);
        i_event    = '0;
        i_miss_clr = '1;
        tick();
        i_miss_clr = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_event = 4'($urandom);
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== 12'h000) begin
                n_mis++;
                $display("FAIL test_reset cyc=%0d got spike=%h busy=%h miss=%h exp all 0",
                         cyc, o_spike, o_busy, o_miss);
            end
        end
        i_event = '0;
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_single();
        int spikes = 0, first = -1;
        i_mode = 2'b00; i_pulse_len = 4'd1; i_refrac_len = 8'd0; i_en = 1'b1;
        settle(4);
        for (int i = 0; i < 10; i++) begin
            i_event[0] = (i == 0);
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_single cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            if (o_spike[0]) begin spikes++; if (first < 0) first = i; end
        end
        n_vec++;
        if (spikes != 1 || first != 2 || o_miss[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL test_single_shape got cycles=%0d first=%0d miss=%b exp 1/2/0",
                     spikes, first, o_miss[0]);
        end
    endtask

    task automatic test_missed();
        int busy_n = 0, spk_n = 0;
        i_mode = 2'b00; i_pulse_len = 4'd4; i_refrac_len = 8'd10;
        settle(4);
        for (int i = 0; i < 30; i++) begin
            i_event[1] = (i % 3 == 0) && (i < 9);
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_missed cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            busy_n += int'(o_busy[1]);
            spk_n  += int'(o_spike[1]);
        end
        n_vec++;
        if (busy_n != 14 || spk_n != 4 || o_miss[1] !== 1'b1) begin
            n_mis++;
            $display("FAIL test_missed_shape got busy=%0d spike=%0d miss=%b exp 14/4/1",
                     busy_n, spk_n, o_miss[1]);
        end
        i_miss_clr = 4'b0010;
        tick();
        i_miss_clr = '0;
        n_vec++;
        if (o_miss[1] !== 1'b0 || o_miss !== m_miss) begin
            n_mis++;
            $display("FAIL test_miss_clr got miss=%h exp %h", o_miss, m_miss);
        end
    endtask

    task automatic test_both_edges();
        int spk_n = 0, rises = 0;
        logic last = 1'b0;
        i_mode = 2'b10; i_pulse_len = 4'd2; i_refrac_len = 8'd0;
        settle(4);
        for (int i = 0; i < 14; i++) begin
            i_event[2] = (i < 5);
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_both_edges cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            spk_n += int'(o_spike[2]);
            if (o_spike[2] && !last) rises++;
            last = o_spike[2];
        end
        n_vec++;
        if (spk_n != 4 || rises != 2) begin
            n_mis++;
            $display("FAIL test_both_edges_shape got cycles=%0d spikes=%0d exp 4/2", spk_n, rises);
        end
    endtask

    task automatic test_reset_mid();
        int wait_n = -1;
        i_mode = 2'b00; i_pulse_len = 4'd8; i_refrac_len = 8'd0;
        settle(4);
        i_event[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        i_rst_n = 1'b0;
        tick();
        n_vec++;
        if ({o_spike, o_busy, o_miss} !== 12'h000 || {m_spike, m_busy, m_miss} !== 12'h000) begin
            n_mis++;
            $display("FAIL test_reset_mid_drop got %h/%h/%h exp 0/0/0", o_spike, o_busy, o_miss);
        end
        tick();
        i_rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_reset_mid cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            if (o_spike[0] && wait_n < 0) wait_n = i;
        end
        n_vec++;
        if (wait_n != SS + 1) begin
            n_mis++;
            $display("FAIL test_reset_mid_latency got %0d edges exp %0d", wait_n, SS + 1);
        end
    endtask

    task automatic test_simultaneous();
        int spk_n [NCH];
        i_mode = 2'b00; i_pulse_len = 4'd3; i_refrac_len = 8'd0;
        settle(4);
        for (int c = 0; c < NCH; c++) spk_n[c] = 0;
        for (int i = 0; i < 10; i++) begin
            i_event = '1;
            if (i == 3) i_pulse_len = 4'd15;
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_simultaneous cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            if (i == 2) begin
                n_vec++;
                if (o_spike !== 4'hF) begin
                    n_mis++;
                    $display("FAIL test_simultaneous_all got spike=%h exp f", o_spike);
                end
            end
            for (int c = 0; c < NCH; c++) spk_n[c] += int'(o_spike[c]);
        end
        for (int c = 0; c < NCH; c++) begin
            n_vec++;
            if (spk_n[c] != 3) begin
                n_mis++;
                $display("FAIL test_simultaneous_len ch=%0d got %0d exp 3", c, spk_n[c]);
            end
        end
    endtask

    task automatic test_enable_zero();
        int spk_n = 0;
        i_mode = 2'b00; i_pulse_len = 4'd5; i_refrac_len = 8'd0;
        settle(20);
        i_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_event[3] = 1'b1;
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_enable_zero cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            spk_n += int'(o_spike[3]);
        end
        n_vec++;
        if (spk_n != 0 || o_miss[3] !== 1'b1) begin
            n_mis++;
            $display("FAIL test_enable_zero_miss got spikes=%0d miss=%b exp 0/1", spk_n, o_miss[3]);
        end
        i_en = 1'b1; i_pulse_len = 4'd0;
        settle(4);
        spk_n = 0;
        for (int i = 0; i < 6; i++) begin
            i_event[3] = 1'b1;
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_len_zero cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
            spk_n += int'(o_spike[3]);
        end
        n_vec++;
        if (spk_n != 1) begin
            n_mis++;
            $display("FAIL test_len_zero_width got %0d exp 1", spk_n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 9) == 0) i_event[c] = ~i_event[c];
            i_en         = ($urandom_range(0, 7) != 0);
            if (i % 50 == 0) i_mode = 2'($urandom);
            i_pulse_len  = 4'($urandom);
            i_refrac_len = 8'($urandom_range(0, 20));
            i_miss_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            i_rst_n      = ($urandom_range(0, 149) != 0);
            tick();
            n_vec++;
            if ({o_spike, o_busy, o_miss} !== {m_spike, m_busy, m_miss}) begin
                n_mis++;
                $display("FAIL test_random cyc=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, o_spike, o_busy, o_miss, m_spike, m_busy, m_miss);
            end
        end
        i_rst_n = 1'b1;
        i_miss_clr = '0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_event = '0; i_en = 1'b1; i_mode = 2'b00;
        i_pulse_len = 4'd1; i_refrac_len = 8'd0; i_miss_clr = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i <= SS; i++) hist[c][i] = 1'b0;
            start_t[c] = -1000; spk_end[c] = -1000; busy_end[c] = -1000;
        end
        m_spike = '0; m_busy = '0; m_miss = '0;
        @(negedge i_clk);
        test_reset();
        test_single();
        test_missed();
        test_both_edges();
        test_reset_mid();
        test_simultaneous();
        test_enable_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
